// File: rtl/pipe_hazard_if.sv
// Hazard-control bundle between the datapath and the pipeline sequencer.
// The master modport is the sequencer, which drives the stage controls.
// The slave modport is the datapath side, which reports hazard conditions.
interface pipe_hazard_if #(
  parameter int CNT_W = 16
) ();
  logic             id_ex_memread;
  logic [4:0]       id_ex_rd;
  logic [4:0]       if_id_rs1;
  logic [4:0]       if_id_rs2;
  logic             branch_taken;
  logic             dmem_req;
  logic             dmem_ready;
  logic             halt_req;
  logic             resume;
  logic             pc_en;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_ex_en;
  logic             id_ex_bubble;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic             halted;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    input  id_ex_memread, id_ex_rd, if_id_rs1, if_id_rs2, branch_taken,
           dmem_req, dmem_ready, halt_req, resume,
    output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble,
           ex_mem_en, mem_wb_en, halted, mem_err, stall_cnt, flush_cnt
  );

  modport slave (
    output id_ex_memread, id_ex_rd, if_id_rs1, if_id_rs2, branch_taken,
           dmem_req, dmem_ready, halt_req, resume,
    input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble,
           ex_mem_en, mem_wb_en, halted, mem_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central sequencer for the 5-stage core: PC/stage enables, IF/ID flush and
// ID/EX bubble, plus the RUN -> DRAIN -> HALT sequence and a memory-wait
// watchdog. Stage controls are Mealy outputs so the pipeline registers react
// on the same edge the hazard is seen.
module pipe_hazard_ctrl #(
  parameter int DRAIN_CYC   = 3,
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 16
) (
  input  logic          clk,
  input  logic          arst,
  pipe_hazard_if.master bus
);

  localparam int DRW = (DRAIN_CYC < 1) ? 1 : $clog2(DRAIN_CYC + 1);
  localparam int WTW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_HALT  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [DRW-1:0]   drain_q, drain_d;
  logic [WTW-1:0]   wait_q, wait_d;
  logic             pend_q, pend_d;
  logic             halted_q, halted_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic mem_stall_s;
  logic load_use_s;
  logic timeout_s;
  logic pc_en_s, if_id_en_s, if_id_flush_s, id_ex_en_s, id_ex_bubble_s;
  logic ex_mem_en_s, mem_wb_en_s;

  // Saturating increment for the performance counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_W'(1);
    end
  endfunction

  assign mem_stall_s = bus.dmem_req & ~bus.dmem_ready;
  assign load_use_s  = bus.id_ex_memread & (bus.id_ex_rd != 5'd0) &
                       ((bus.id_ex_rd == bus.if_id_rs1) | (bus.id_ex_rd == bus.if_id_rs2));
  // The cycle that brings the wait counter up to TIMEOUT_CYC forces HALT.
  assign timeout_s   = (state_q != S_HALT) & mem_stall_s &
                       (wait_q >= WTW'(TIMEOUT_CYC - 1));

  // Stage controls and next-state/counter updates from state and hazards.
  always_comb begin
    pc_en_s        = 1'b0;
    if_id_en_s     = 1'b0;
    if_id_flush_s  = 1'b0;
    id_ex_en_s     = 1'b0;
    id_ex_bubble_s = 1'b0;
    ex_mem_en_s    = 1'b0;
    mem_wb_en_s    = 1'b0;
    state_d        = state_q;
    drain_d        = drain_q;
    pend_d         = pend_q;
    err_d          = err_q;
    stall_d        = stall_q;
    flush_d        = flush_q;

    if ((state_q != S_HALT) && mem_stall_s) begin
      wait_d = wait_q + WTW'(1);
    end else begin
      wait_d = {WTW{1'b0}};
    end

    case (state_q)
      S_RUN: begin
        if (mem_stall_s) begin
          // Freeze everything; a halt request waits for the stall to clear.
          stall_d = sat_inc(stall_q);
          if (bus.halt_req) begin
            pend_d = 1'b1;
          end else begin
            pend_d = pend_q;
          end
        end else if (bus.branch_taken) begin
          pc_en_s        = 1'b1;
          if_id_en_s     = 1'b1;
          if_id_flush_s  = 1'b1;
          id_ex_en_s     = 1'b1;
          id_ex_bubble_s = 1'b1;
          ex_mem_en_s    = 1'b1;
          mem_wb_en_s    = 1'b1;
          flush_d        = sat_inc(flush_q);
        end else if (load_use_s) begin
          // Hold PC and IF/ID, insert a bubble so the load advances.
          id_ex_en_s     = 1'b1;
          id_ex_bubble_s = 1'b1;
          ex_mem_en_s    = 1'b1;
          mem_wb_en_s    = 1'b1;
          stall_d        = sat_inc(stall_q);
        end else begin
          pc_en_s     = 1'b1;
          if_id_en_s  = 1'b1;
          id_ex_en_s  = 1'b1;
          ex_mem_en_s = 1'b1;
          mem_wb_en_s = 1'b1;
        end

        if (!mem_stall_s && (bus.halt_req || pend_q)) begin
          state_d = S_DRAIN;
          drain_d = DRW'(DRAIN_CYC);
          pend_d  = 1'b0;
        end else begin
          state_d = S_RUN;
        end
      end

      S_DRAIN: begin
        if (mem_stall_s) begin
          drain_d = drain_q;
        end else begin
          // Fetch stopped: keep squashing the front end, let EX/MEM/WB retire.
          if_id_en_s     = 1'b1;
          if_id_flush_s  = 1'b1;
          id_ex_en_s     = 1'b1;
          id_ex_bubble_s = 1'b1;
          ex_mem_en_s    = 1'b1;
          mem_wb_en_s    = 1'b1;
          if (drain_q <= DRW'(1)) begin
            state_d = S_HALT;
            drain_d = {DRW{1'b0}};
          end else begin
            drain_d = drain_q - DRW'(1);
          end
        end
      end

      S_HALT: begin
        if (bus.resume && !err_q) begin
          state_d = S_RUN;
        end else begin
          state_d = S_HALT;
        end
      end

      default: begin
        state_d = S_RUN;
      end
    endcase

    if (timeout_s) begin
      state_d = S_HALT;
      err_d   = 1'b1;
      pend_d  = 1'b0;
      drain_d = {DRW{1'b0}};
      wait_d  = {WTW{1'b0}};
    end else begin
      err_d = err_d;
    end

    halted_d = (state_d == S_HALT);
  end

  // State, sticky flags and counters.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q  <= S_RUN;
      drain_q  <= {DRW{1'b0}};
      wait_q   <= {WTW{1'b0}};
      pend_q   <= 1'b0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
      stall_q  <= {CNT_W{1'b0}};
      flush_q  <= {CNT_W{1'b0}};
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      wait_q   <= wait_d;
      pend_q   <= pend_d;
      halted_q <= halted_d;
      err_q    <= err_d;
      stall_q  <= stall_d;
      flush_q  <= flush_d;
    end
  end

  assign bus.pc_en        = pc_en_s;
  assign bus.if_id_en     = if_id_en_s;
  assign bus.if_id_flush  = if_id_flush_s;
  assign bus.id_ex_en     = id_ex_en_s;
  assign bus.id_ex_bubble = id_ex_bubble_s;
  assign bus.ex_mem_en    = ex_mem_en_s;
  assign bus.mem_wb_en    = mem_wb_en_s;
  assign bus.halted       = halted_q;
  assign bus.mem_err      = err_q;
  assign bus.stall_cnt    = stall_q;
  assign bus.flush_cnt    = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: a table of per-cycle vectors with hand-derived
// expected controls and counters, pushed to a queue when driven and popped
// when the outputs are sampled on the falling edge; then reset sequences.
module tb_pipe_hazard_ctrl;

  localparam logic [6:0] NORM = 7'b1101011; // {pc,ifid_en,flush,idex_en,bubble,exmem,memwb}
  localparam logic [6:0] FRZ  = 7'b0000000;
  localparam logic [6:0] BR   = 7'b1111111;
  localparam logic [6:0] LU   = 7'b0001111;
  localparam logic [6:0] DRN  = 7'b0111111;
  localparam logic [6:0] HLT  = 7'b0000000;

  typedef struct {
    logic        mr;
    logic [4:0]  rd, rs1, rs2;
    logic        br, req, rdy, hreq, res;
    logic [6:0]  ctrl;
    logic        halted, err;
    logic [15:0] scnt, fcnt;
  } vec_t;

  logic clk;
  logic arst;
  int   checks;
  int   errors;
  vec_t tbl[$];
  vec_t exp_q[$];

  pipe_hazard_if #(.CNT_W(16)) bus ();

  pipe_hazard_ctrl #(.DRAIN_CYC(3), .TIMEOUT_CYC(8), .CNT_W(16)) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic br, input logic req,
                              input logic rdy, input logic hreq, input logic res,
                              input logic [6:0] ctrl, input logic halted, input logic err,
                              input logic [15:0] scnt, input logic [15:0] fcnt);
    vec_t v;
    v.mr = mr; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.br = br; v.req = req; v.rdy = rdy; v.hreq = hreq; v.res = res;
    v.ctrl = ctrl; v.halted = halted; v.err = err; v.scnt = scnt; v.fcnt = fcnt;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.id_ex_memread = v.mr;
    bus.id_ex_rd      = v.rd;
    bus.if_id_rs1     = v.rs1;
    bus.if_id_rs2     = v.rs2;
    bus.branch_taken  = v.br;
    bus.dmem_req      = v.req;
    bus.dmem_ready    = v.rdy;
    bus.halt_req      = v.hreq;
    bus.resume        = v.res;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic compare(input vec_t e, input string tag);
    logic [6:0] ctrl;
    ctrl = {bus.pc_en, bus.if_id_en, bus.if_id_flush, bus.id_ex_en,
            bus.id_ex_bubble, bus.ex_mem_en, bus.mem_wb_en};
    check({tag, ".ctrl"},   {9'd0, ctrl},        {9'd0, e.ctrl});
    check({tag, ".halted"}, {15'd0, bus.halted},  {15'd0, e.halted});
    check({tag, ".mem_err"},{15'd0, bus.mem_err}, {15'd0, e.err});
    check({tag, ".stall"},  bus.stall_cnt,        e.scnt);
    check({tag, ".flush"},  bus.flush_cnt,        e.fcnt);
  endtask

  // One clock cycle: drive after the rising edge, compare on the falling edge.
  task automatic apply(input vec_t v, input string tag);
    vec_t e;
    @(posedge clk);
    #1;
    drive(v);
    exp_q.push_back(v);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      compare(e, tag);
    end
  endtask

  initial begin
    vec_t idle;
    checks = 0;
    errors = 0;
    idle = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NORM, 1'b0, 1'b0, 16'd0, 16'd0);

    //          mr    rd     rs1    rs2    br    req   rdy   hreq  res   ctrl  hlt   err   stall   flush
    tbl.push_back(mk(1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NORM, 1'b0, 1'b0, 16'd0,  16'd0)); // 0 idle
    tbl.push_back(mk(1'b1, 5'd5,  5'd0,  5'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, LU,   1'b0, 1'b0, 16'd0,  16'd0)); // 1 load-use rs2
    tbl.push_back(mk(1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NORM, 1'b0, 1'b0, 16'd1,  16'd0)); // 2
    tbl.push_back(mk(1'b1, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NORM, 1'b0, 1'b0, 16'd1,  16'd0)); // 3 rd=0, no stall
    tbl.push_back(mk(1'b1, 5'd7,  5'd7,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, BR,   1'b0, 1'b0, 16'd1,  16'd0)); // 4 branch beats load-use
    tbl.push_back(mk(1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NORM, 1'b0, 1'b0, 16'd1,  16'd1)); // 5
    for (int i = 0; i < 4; i++)                                                                                   // 6-9 mem stall
      tbl.push_back(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, FRZ, 1'b0, 1'b0, 16'(1 + i), 16'd1));
    tbl.push_back(mk(1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, NORM, 1'b0, 1'b0, 16'd5,  16'd1)); // 10 ready
    tbl.push_back(mk(1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, FRZ,  1'b0, 1'b0, 16'd5,  16'd1)); // 11 freeze beats branch
    tbl.push_back(mk(1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, BR,   1'b0, 1'b0, 16'd6,  16'd1)); // 12 branch again
    tbl.push_back(mk(1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NORM, 1'b0, 1'b0, 16'd6,  16'd2)); // 13
    tbl.push_back(mk(1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, NORM, 1'b0, 1'b0, 16'd6,  16'd2)); // 14 halt_req
    tbl.push_back(mk(1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, DRN,  1'b0, 1'b0, 16'd6,  16'd2)); // 15 drain, branch ignored
    tbl.push_back(mk(1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, FRZ,  1'b0, 1'b0, 16'd6,  16'd2)); // 16 drain stall
    tbl.push_back(mk(1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, DRN,  1'b0, 1'b0, 16'd6,  16'd2)); // 17
    tbl.push_back(mk(1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, DRN,  1'b0, 1'b0, 16'd6,  16'd2)); // 18
    tbl.push_back(mk(1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, HLT,  1'b1, 1'b0, 16'd6,  16'd2)); // 19 halted (+5)
    tbl.push_back(mk(1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, HLT,  1'b1, 1'b0, 16'd6,  16'd2)); // 20 resume
    tbl.push_back(mk(1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NORM, 1'b0, 1'b0, 16'd6,  16'd2)); // 21 running
    tbl.push_back(mk(1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, FRZ,  1'b0, 1'b0, 16'd6,  16'd2)); // 22 halt during stall
    tbl.push_back(mk(1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, NORM, 1'b0, 1'b0, 16'd7,  16'd2)); // 23 pending taken
    for (int i = 0; i < 3; i++)                                                                                   // 24-26 drain
      tbl.push_back(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, DRN, 1'b0, 1'b0, 16'd7, 16'd2));
    tbl.push_back(mk(1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, HLT,  1'b1, 1'b0, 16'd7,  16'd2)); // 27
    tbl.push_back(mk(1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, HLT,  1'b1, 1'b0, 16'd7,  16'd2)); // 28 resume
    tbl.push_back(mk(1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NORM, 1'b0, 1'b0, 16'd7,  16'd2)); // 29
    for (int i = 0; i < 8; i++)                                                                                   // 30-37 timeout run
      tbl.push_back(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, FRZ, 1'b0, 1'b0, 16'(7 + i), 16'd2));
    tbl.push_back(mk(1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, HLT,  1'b1, 1'b1, 16'd15, 16'd2)); // 38 mem_err
    tbl.push_back(mk(1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, HLT,  1'b1, 1'b1, 16'd15, 16'd2)); // 39 resume ignored
    tbl.push_back(mk(1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, HLT,  1'b1, 1'b1, 16'd15, 16'd2)); // 40

    // Reset with idle inputs.
    drive(idle);
    arst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    compare(idle, "reset_hold");
    arst = 1'b0;

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // Asynchronous reset clears the sticky error and counters at once.
    @(posedge clk);
    #1;
    drive(idle);
    #2;
    arst = 1'b1;
    #1;
    compare(idle, "arst_from_err");
    #1;
    arst = 1'b0;

    // Reset in the middle of a drain returns straight to RUN.
    apply(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, NORM, 1'b0, 1'b0, 16'd0, 16'd0), "md_halt");
    apply(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, DRN,  1'b0, 1'b0, 16'd0, 16'd0), "md_drain");
    #1;
    arst = 1'b1;
    #1;
    compare(idle, "arst_mid_drain");
    #1;
    arst = 1'b0;
    for (int i = 0; i < 5; i++) apply(idle, $sformatf("post_drain_rst%0d", i));

    // Reset in the middle of a memory stall, counters restart from zero.
    apply(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, FRZ, 1'b0, 1'b0, 16'd0, 16'd0), "ms0");
    apply(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, FRZ, 1'b0, 1'b0, 16'd1, 16'd0), "ms1");
    #1;
    arst = 1'b1;
    #1;
    drive(idle);
    #1;
    compare(idle, "arst_mid_stall");
    arst = 1'b0;
    apply(idle, "post_stall_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central pipeline sequencer for the 5-stage 64-bit core. It generates the PC enable and the per-stage enable, flush and bubble controls for the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves load-use stalls, taken-branch flushes and data-memory wait states, and runs a halt/drain/resume sequence. It sits beside the datapath and replaces the ad-hoc hazard/flush wiring.

## Interface
- `DRAIN_CYC`, default 3: cycles of downstream execution after fetch stops on a halt request.
- `TIMEOUT_CYC`, default 64: consecutive memory-wait cycles before `mem_err`.
- `CNT_W`, default 16: width of the performance counters.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `arst`  in  1  asynchronous, active-high reset.
- `id_ex_memread`  in  1  instruction in EX is a load.
- `id_ex_rd`  in  5  destination register of the instruction in EX.
- `if_id_rs1`, `if_id_rs2`  in  5 each  source registers of the instruction in ID.
- `branch_taken`  in  1  EX resolved a taken branch or jump this cycle.
- `dmem_req`  in  1  MEM stage is accessing data memory.
- `dmem_ready`  in  1  data memory completes the access this cycle.
- `halt_req`  in  1  single-cycle pulse requesting a halt.
- `resume`  in  1  single-cycle pulse; leave HALT.
- `pc_en`  out  1  PC register loads.
- `if_id_en`  out  1  IF/ID register loads.
- `if_id_flush`  out  1  IF/ID loads zero (NOP).
- `id_ex_en`  out  1  ID/EX register loads.
- `id_ex_bubble`  out  1  ID/EX loads zero control fields.
- `ex_mem_en`  out  1  EX/MEM register loads.
- `mem_wb_en`  out  1  MEM/WB register loads.
- `halted`  out  1  state is HALT.
- `mem_err`  out  1  sticky memory-timeout flag.
- `stall_cnt`  out  CNT_W  count of stall cycles.
- `flush_cnt`  out  CNT_W  count of branch flushes.

## Operation
- States are RUN, DRAIN and HALT. Reset enters RUN.
- Derived terms:
  - `mem_stall` = `dmem_req & ~dmem_ready`.
  - `load_use` = `id_ex_memread & (id_ex_rd != 0) & (id_ex_rd == if_id_rs1 | id_ex_rd == if_id_rs2)`.
- The stage controls are combinational (Mealy) from the state and inputs. In RUN the priority order is highest first:
  1. `mem_stall`: all five enables are 0. Flush and bubble are 0.
  2. `branch_taken`: all enables are 1, plus `if_id_flush`=1 and `id_ex_bubble`=1. `flush_cnt`++.
  3. `load_use`: `pc_en`=0, `if_id_en`=0, `id_ex_bubble`=1. EX/MEM and MEM/WB are enabled.
  4. Otherwise: all enables are 1, flush and bubble are 0.
- `stall_cnt`++ in every RUN cycle with `pc_en`=0 (rules 1 and 3).
- A `halt_req` in RUN with no `mem_stall` moves to DRAIN next cycle and loads the drain counter with `DRAIN_CYC`. A `halt_req` during `mem_stall` is held pending until the stall clears.
- DRAIN:
  - `pc_en`=0, `if_id_flush`=1, `id_ex_bubble`=1. EX/MEM and MEM/WB are enabled.
  - `branch_taken` is ignored.
  - `mem_stall` freezes all enables and pauses the drain counter.
  - The counter decrements on each non-stalled cycle. At 0 the block enters HALT.
- HALT: all enables are 0 and `halted`=1. `resume` returns to RUN next cycle, but is ignored while `mem_err`=1.
- Timeout:
  - The wait counter increments on each consecutive `mem_stall` cycle in RUN or DRAIN and clears on any non-stall cycle.
  - When it reaches `TIMEOUT_CYC`, the next state is HALT and `mem_err` is set. Only `arst` clears `mem_err`.
- Counters saturate at all-ones. They are not cleared by HALT or resume.

## Timing
- Reset values:
  - state RUN, `halted`=0, `mem_err`=0, `stall_cnt`=0, `flush_cnt`=0, drain and wait counters 0, halt-pending 0.
  - The enables then follow the RUN rules combinationally. With idle inputs, all enables are 1 and flush and bubble are 0.
- `arst` mid-drain or mid-stall aborts immediately into RUN with all registered state at its reset value.
- Control latency is 0 cycles. The pipeline registers act on the same clock edge.
- A load-use stall lasts exactly 1 cycle: the load advances and the condition drops.
- Simultaneous events:
  - `branch_taken` with `load_use`: flush wins and no stall is counted.
  - `mem_stall` with `branch_taken`: freeze wins. The branch is re-presented next cycle because EX is held.
- Halt latency is `DRAIN_CYC` non-stalled cycles plus 1 cycle from `halt_req` to `halted`=1.

## Test plan
- Reset, then idle inputs: all enables = 1, `halted`=0, both counters = 0.
- `id_ex_memread`=1, `id_ex_rd`=5, `if_id_rs2`=5 for 1 cycle: `pc_en`=`if_id_en`=0 and `id_ex_bubble`=1 for that cycle; `stall_cnt`=1. Repeat with `id_ex_rd`=0: no stall.
- `branch_taken` together with a load-use match: `if_id_flush`=1, `id_ex_bubble`=1, `pc_en`=1; `flush_cnt`=1, `stall_cnt` unchanged.
- `dmem_req`=1 with `dmem_ready`=0 for 4 cycles, then 1: all enables 0 for 4 cycles; `stall_cnt`=4; normal operation on cycle 5.
- `halt_req` pulse, with one `mem_stall` cycle during drain: `halted`=1 exactly 5 cycles after the pulse; `resume` gives RUN on the next cycle.
- `TIMEOUT_CYC`=8 with `dmem_ready` held at 0: `mem_err`=1 and `halted`=1 after the 8th stall cycle; `resume` ignored; `arst` clears both.
